// File: rtl/input_read_scheduler.sv
// Round-robin scheduler for the px1 / px2 / weight read-command streams feeding the read DMA.
// Each stream is limited to MAX_OUT commands in flight; credits are returned by done pulses.
module input_read_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 23,
    parameter int MAX_OUT    = 4,
    parameter int COPIES     = 2
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  s_px1_cmd_valid,
    output logic                  s_px1_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] s_px1_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  s_px1_cmd_len,

    input  logic                  s_px2_cmd_valid,
    output logic                  s_px2_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] s_px2_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  s_px2_cmd_len,

    input  logic                  s_w_cmd_valid,
    output logic                  s_w_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] s_w_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  s_w_cmd_len,

    output logic                  m_cmd_valid,
    input  logic                  m_cmd_ready,
    output logic [ADDR_WIDTH-1:0] m_cmd_addr,
    output logic [LEN_WIDTH-1:0]  m_cmd_len,
    output logic [1:0]            m_cmd_id,

    input  logic                  done_px1,
    input  logic                  done_px2,
    input  logic                  done_w,

    output logic [2:0]            out_px1,
    output logic [2:0]            out_px2,
    output logic [2:0]            out_w,
    output logic                  err_underflow,
    output logic                  busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;
    localparam int         NS       = 3;
    localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

    logic [0:0]            state_reg, state_next;
    logic [1:0]            ptr_reg, ptr_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [LEN_WIDTH-1:0]  len_reg, len_next;
    logic [1:0]            id_reg, id_next;
    logic                  err_reg, err_next;

    logic [NS-1:0]         req_valid;
    logic [NS-1:0]         req_eligible;
    logic [NS-1:0]         req_ready;
    logic [NS-1:0]         done_vec;
    logic [NS-1:0]         cnt_inc;
    logic [NS-1:0]         cnt_dec;
    logic [NS-1:0]         uflow;
    logic [NS-1:0]         cnt_nonzero;
    logic [ADDR_WIDTH-1:0] req_addr [NS];
    logic [LEN_WIDTH-1:0]  req_len  [NS];
    logic [2:0]            cnt_q    [NS];

    logic                  grant_any;
    logic [1:0]            grant_idx;
    logic                  grant_zero;
    logic                  issue_accept;

    assign req_valid = {s_w_cmd_valid, s_px2_cmd_valid, s_px1_cmd_valid};
    assign done_vec  = {done_w, done_px2, done_px1};

    assign req_addr[0] = s_px1_cmd_addr;
    assign req_addr[1] = s_px2_cmd_addr;
    assign req_addr[2] = s_w_cmd_addr;
    assign req_len[0]  = s_px1_cmd_len;
    assign req_len[1]  = s_px2_cmd_len;
    assign req_len[2]  = s_w_cmd_len;

    assign issue_accept = (state_reg == ST_ISSUE) && m_cmd_ready;

    function automatic logic [1:0] wrap_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Per-stream credit counter, eligibility and ready decode.
    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_stream
            localparam bit PRESENT = (gi != 1) || (COPIES > 1);

            logic [2:0] cnt_reg, cnt_next;

            assign req_eligible[gi] = PRESENT && req_valid[gi] && (cnt_reg < MAX_OUT_C);
            assign cnt_inc[gi]      = issue_accept && (id_reg == 2'(gi));
            assign cnt_dec[gi]      = PRESENT && done_vec[gi];
            assign uflow[gi]        = cnt_dec[gi] && !cnt_inc[gi] && (cnt_reg == 3'd0);
            assign cnt_nonzero[gi]  = (cnt_reg != 3'd0);
            assign cnt_q[gi]        = cnt_reg;
            assign req_ready[gi]    = (state_reg == ST_IDLE) && grant_any && (grant_idx == 2'(gi));

            always_comb begin
                cnt_next = cnt_reg;
                if (cnt_inc[gi] && !cnt_dec[gi]) begin
                    cnt_next = cnt_reg + 3'd1;
                end else if (cnt_dec[gi] && !cnt_inc[gi] && (cnt_reg != 3'd0)) begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end

            always_ff @(posedge aclk) begin
                if (areset) begin
                    cnt_reg <= 3'd0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    // Search starts at ptr_reg, which always points just past the last grant.
    always_comb begin
        logic [1:0] cand;
        grant_any = 1'b0;
        grant_idx = 2'd0;
        cand      = ptr_reg;
        for (int k = 0; k < NS; k++) begin
            if (!grant_any && req_eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
            cand = wrap_next(cand);
        end
    end

    assign grant_zero = (req_len[grant_idx] == '0);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        id_next    = id_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    ptr_next = wrap_next(grant_idx);
                    // Zero-length commands are swallowed without touching the DMA or credits.
                    if (!grant_zero) begin
                        state_next = ST_ISSUE;
                        addr_next  = req_addr[grant_idx];
                        len_next   = req_len[grant_idx];
                        id_next    = grant_idx;
                    end
                end
            end
            default: begin
                if (m_cmd_ready) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    assign err_next = err_reg | (|uflow);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= 2'd0;
            addr_reg  <= '0;
            len_reg   <= '0;
            id_reg    <= 2'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            addr_reg  <= addr_next;
            len_reg   <= len_next;
            id_reg    <= id_next;
            err_reg   <= err_next;
        end
    end

    assign s_px1_cmd_ready = req_ready[0];
    assign s_px2_cmd_ready = req_ready[1];
    assign s_w_cmd_ready   = req_ready[2];

    assign m_cmd_valid   = (state_reg == ST_ISSUE);
    assign m_cmd_addr    = addr_reg;
    assign m_cmd_len     = len_reg;
    assign m_cmd_id      = id_reg;

    assign out_px1       = cnt_q[0];
    assign out_px2       = cnt_q[1];
    assign out_w         = cnt_q[2];
    assign err_underflow = err_reg;
    assign busy          = (state_reg == ST_ISSUE) || (|cnt_nonzero);

endmodule

// File: tb/tb_input_read_scheduler.sv
// Directed bench for input_read_scheduler: a COPIES=2 instance and a COPIES=1 instance share stimulus,
// and each has a scoreboard of expected DMA commands checked on every m_cmd handshake.
module tb_input_read_scheduler;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [22:0] len;
    } cmd_t;

    logic        aclk;
    logic        areset;
    logic        s_px1_cmd_valid, s_px2_cmd_valid, s_w_cmd_valid;
    logic [31:0] s_px1_cmd_addr, s_px2_cmd_addr, s_w_cmd_addr;
    logic [22:0] s_px1_cmd_len, s_px2_cmd_len, s_w_cmd_len;
    logic        m_cmd_ready;
    logic        done_px1, done_px2, done_w;

    logic        s_px1_cmd_ready, s_px2_cmd_ready, s_w_cmd_ready;
    logic        m_cmd_valid;
    logic [31:0] m_cmd_addr;
    logic [22:0] m_cmd_len;
    logic [1:0]  m_cmd_id;
    logic [2:0]  out_px1, out_px2, out_w;
    logic        err_underflow, busy;

    logic        s1_px1_cmd_ready, s1_px2_cmd_ready, s1_w_cmd_ready;
    logic        m1_cmd_valid;
    logic [31:0] m1_cmd_addr;
    logic [22:0] m1_cmd_len;
    logic [1:0]  m1_cmd_id;
    logic [2:0]  out1_px1, out1_px2, out1_w;
    logic        err1_underflow, busy1;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   r_px1, r_px2, r_w, r1_px2;
    bit   mon_en = 1'b0;
    bit   mon1_en = 1'b0;
    cmd_t exp_q[$];
    cmd_t exp1_q[$];
    int   acc_t[$];

    input_read_scheduler #(.ADDR_WIDTH(32), .LEN_WIDTH(23), .MAX_OUT(4), .COPIES(2)) dut (
        .aclk(aclk), .areset(areset),
        .s_px1_cmd_valid(s_px1_cmd_valid), .s_px1_cmd_ready(s_px1_cmd_ready),
        .s_px1_cmd_addr(s_px1_cmd_addr), .s_px1_cmd_len(s_px1_cmd_len),
        .s_px2_cmd_valid(s_px2_cmd_valid), .s_px2_cmd_ready(s_px2_cmd_ready),
        .s_px2_cmd_addr(s_px2_cmd_addr), .s_px2_cmd_len(s_px2_cmd_len),
        .s_w_cmd_valid(s_w_cmd_valid), .s_w_cmd_ready(s_w_cmd_ready),
        .s_w_cmd_addr(s_w_cmd_addr), .s_w_cmd_len(s_w_cmd_len),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len), .m_cmd_id(m_cmd_id),
        .done_px1(done_px1), .done_px2(done_px2), .done_w(done_w),
        .out_px1(out_px1), .out_px2(out_px2), .out_w(out_w),
        .err_underflow(err_underflow), .busy(busy)
    );

    input_read_scheduler #(.ADDR_WIDTH(32), .LEN_WIDTH(23), .MAX_OUT(4), .COPIES(1)) dut1 (
        .aclk(aclk), .areset(areset),
        .s_px1_cmd_valid(s_px1_cmd_valid), .s_px1_cmd_ready(s1_px1_cmd_ready),
        .s_px1_cmd_addr(s_px1_cmd_addr), .s_px1_cmd_len(s_px1_cmd_len),
        .s_px2_cmd_valid(s_px2_cmd_valid), .s_px2_cmd_ready(s1_px2_cmd_ready),
        .s_px2_cmd_addr(s_px2_cmd_addr), .s_px2_cmd_len(s_px2_cmd_len),
        .s_w_cmd_valid(s_w_cmd_valid), .s_w_cmd_ready(s1_w_cmd_ready),
        .s_w_cmd_addr(s_w_cmd_addr), .s_w_cmd_len(s_w_cmd_len),
        .m_cmd_valid(m1_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_cmd_addr(m1_cmd_addr), .m_cmd_len(m1_cmd_len), .m_cmd_id(m1_cmd_id),
        .done_px1(done_px1), .done_px2(done_px2), .done_w(done_w),
        .out_px1(out1_px1), .out_px2(out1_px2), .out_w(out1_w),
        .err_underflow(err1_underflow), .busy(busy1)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit second, input logic [1:0] id, input logic [31:0] a, input logic [22:0] l);
        cmd_t c;
        c.id = id;
        c.addr = a;
        c.len = l;
        if (second) exp1_q.push_back(c);
        else exp_q.push_back(c);
    endtask

    // Scoreboard: every DMA-side handshake must match the oldest expected command.
    always @(negedge aclk) begin
        cmd_t e;
        if (mon_en && m_cmd_valid && m_cmd_ready) begin
            acc_t.push_back(cyc);
            check("cmd_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cmd_id", 32'(m_cmd_id), 32'(e.id));
                check("cmd_addr", m_cmd_addr, e.addr);
                check("cmd_len", 32'(m_cmd_len), 32'(e.len));
            end
        end
        if (mon1_en && m1_cmd_valid && m_cmd_ready) begin
            check("c1_cmd_expected", 32'(exp1_q.size() > 0), 32'd1);
            if (exp1_q.size() > 0) begin
                e = exp1_q.pop_front();
                check("c1_cmd_id", 32'(m1_cmd_id), 32'(e.id));
                check("c1_cmd_addr", m1_cmd_addr, e.addr);
            end
        end
    end

    // Runs n cycles from just after a rising edge, tallying accepted requests.
    task automatic run(input int n);
        repeat (n) begin
            @(negedge aclk);
            r_px1  += int'(s_px1_cmd_valid && s_px1_cmd_ready);
            r_px2  += int'(s_px2_cmd_valid && s_px2_cmd_ready);
            r_w    += int'(s_w_cmd_valid && s_w_cmd_ready);
            r1_px2 += int'(s_px2_cmd_valid && s1_px2_cmd_ready);
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        run(2);
        areset = 1'b0;
    endtask

    task automatic clear_counts();
        r_px1 = 0; r_px2 = 0; r_w = 0; r1_px2 = 0;
    endtask

    task automatic drop_valids();
        s_px1_cmd_valid = 1'b0;
        s_px2_cmd_valid = 1'b0;
        s_w_cmd_valid = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        drop_valids();
        s_px1_cmd_addr = 32'h1000; s_px1_cmd_len = 23'h10;
        s_px2_cmd_addr = 32'h2000; s_px2_cmd_len = 23'h20;
        s_w_cmd_addr   = 32'h3000; s_w_cmd_len   = 23'h30;
        m_cmd_ready = 1'b0;
        done_px1 = 1'b0; done_px2 = 1'b0; done_w = 1'b0;
        clear_counts();
        @(posedge aclk);
        #1;
        run(2);

        // Reset state
        @(negedge aclk);
        check("rst_m_valid", 32'(m_cmd_valid), 32'd0);
        check("rst_out_px1", 32'(out_px1), 32'd0);
        check("rst_out_px2", 32'(out_px2), 32'd0);
        check("rst_out_w", 32'(out_w), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", m_cmd_addr, 32'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // Round-robin with all streams valid
        mon_en = 1'b1;
        m_cmd_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push(1'b0, 2'd0, 32'h1000, 23'h10);
            push(1'b0, 2'd1, 32'h2000, 23'h20);
            push(1'b0, 2'd2, 32'h3000, 23'h30);
        end
        acc_t.delete();
        clear_counts();
        s_px1_cmd_valid = 1'b1; s_px2_cmd_valid = 1'b1; s_w_cmd_valid = 1'b1;
        run(12);
        drop_valids();
        run(2);
        check("rr_grants_px1", 32'(r_px1), 32'd2);
        check("rr_grants_px2", 32'(r_px2), 32'd2);
        check("rr_grants_w", 32'(r_w), 32'd2);
        check("rr_out_px1", 32'(out_px1), 32'd2);
        check("rr_out_px2", 32'(out_px2), 32'd2);
        check("rr_out_w", 32'(out_w), 32'd2);
        check("rr_busy", 32'(busy), 32'd1);
        check("rr_accepts", 32'(acc_t.size()), 32'd6);
        if (acc_t.size() == 6) begin
            for (int k = 1; k < 6; k++) check("rr_spacing", 32'(acc_t[k] - acc_t[k-1]), 32'd2);
        end
        check("rr_queue_empty", 32'(exp_q.size()), 32'd0);

        // Credit limit on the weight stream
        do_reset();
        s_w_cmd_addr = 32'h4000; s_w_cmd_len = 23'h40;
        for (int k = 0; k < 4; k++) push(1'b0, 2'd2, 32'h4000, 23'h40);
        clear_counts();
        s_w_cmd_valid = 1'b1;
        run(20);
        check("cr_grants", 32'(r_w), 32'd4);
        check("cr_out_w_full", 32'(out_w), 32'd4);
        done_w = 1'b1;
        @(negedge aclk);
        check("cr_ready_blocked", 32'(s_w_cmd_ready), 32'd0);
        @(posedge aclk);
        #1;
        done_w = 1'b0;
        push(1'b0, 2'd2, 32'h4000, 23'h40);
        @(negedge aclk);
        check("cr_ready_after_done", 32'(s_w_cmd_ready), 32'd1);
        check("cr_out_w_freed", 32'(out_w), 32'd3);
        @(posedge aclk);
        #1;
        clear_counts();
        run(10);
        check("cr_no_extra_grant", 32'(r_w), 32'd0);
        check("cr_out_w_refull", 32'(out_w), 32'd4);
        check("cr_queue_empty", 32'(exp_q.size()), 32'd0);
        drop_valids();

        // Backpressure and simultaneous credit update
        do_reset();
        s_px1_cmd_addr = 32'h1100; s_px1_cmd_len = 23'h11;
        push(1'b0, 2'd0, 32'h1100, 23'h11);
        push(1'b0, 2'd0, 32'h1100, 23'h11);
        s_px1_cmd_valid = 1'b1;
        run(3);
        s_px1_cmd_valid = 1'b0;
        run(1);
        @(negedge aclk);
        check("bp_out_px1_pre", 32'(out_px1), 32'd2);
        @(posedge aclk);
        #1;
        m_cmd_ready = 1'b0;
        s_px1_cmd_addr = 32'h5000; s_px1_cmd_len = 23'h50;
        s_px1_cmd_valid = 1'b1;
        push(1'b0, 2'd0, 32'h5000, 23'h50);
        @(negedge aclk);
        check("bp_px1_grant", 32'(s_px1_cmd_ready), 32'd1);
        @(posedge aclk);
        #1;
        s_w_cmd_valid = 1'b1;
        s_w_cmd_addr = 32'h3000; s_w_cmd_len = 23'h30;
        clear_counts();
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            check("bp_hold_valid", 32'(m_cmd_valid), 32'd1);
            check("bp_hold_addr", m_cmd_addr, 32'h5000);
            check("bp_hold_len", 32'(m_cmd_len), 32'h50);
            r_px1 += int'(s_px1_cmd_ready);
            r_w   += int'(s_w_cmd_ready);
            @(posedge aclk);
            #1;
        end
        check("bp_no_ready_px1", 32'(r_px1), 32'd0);
        check("bp_no_ready_w", 32'(r_w), 32'd0);
        m_cmd_ready = 1'b1;
        done_px1 = 1'b1;
        drop_valids();
        @(negedge aclk);
        check("bp_accept_valid", 32'(m_cmd_valid), 32'd1);
        @(posedge aclk);
        #1;
        done_px1 = 1'b0;
        @(negedge aclk);
        check("bp_out_px1_same", 32'(out_px1), 32'd2);
        check("bp_back_idle", 32'(m_cmd_valid), 32'd0);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge aclk);
        #1;

        // Zero-length command on px1
        do_reset();
        s_px1_cmd_addr = 32'h6000; s_px1_cmd_len = 23'h0;
        s_px1_cmd_valid = 1'b1;
        @(negedge aclk);
        check("z_ready", 32'(s_px1_cmd_ready), 32'd1);
        @(posedge aclk);
        #1;
        s_px1_cmd_valid = 1'b0;
        @(negedge aclk);
        check("z_no_valid", 32'(m_cmd_valid), 32'd0);
        check("z_out_px1", 32'(out_px1), 32'd0);
        check("z_busy", 32'(busy), 32'd0);
        @(posedge aclk);
        #1;
        s_px1_cmd_addr = 32'h6100; s_px1_cmd_len = 23'h61;
        s_w_cmd_addr = 32'h7000; s_w_cmd_len = 23'h70;
        s_px1_cmd_valid = 1'b1; s_w_cmd_valid = 1'b1;
        @(negedge aclk);
        check("z_ptr_w_ready", 32'(s_w_cmd_ready), 32'd1);
        check("z_ptr_px1_wait", 32'(s_px1_cmd_ready), 32'd0);
        push(1'b0, 2'd2, 32'h7000, 23'h70);
        @(posedge aclk);
        #1;
        drop_valids();
        run(2);
        check("z_queue_empty", 32'(exp_q.size()), 32'd0);
        check("z_out_w", 32'(out_w), 32'd1);

        // COPIES=1 instance: px2 never granted
        mon_en = 1'b0;
        do_reset();
        mon1_en = 1'b1;
        s_px1_cmd_addr = 32'h1000; s_px1_cmd_len = 23'h10;
        s_w_cmd_addr = 32'h3000; s_w_cmd_len = 23'h30;
        for (int k = 0; k < 2; k++) begin
            push(1'b1, 2'd0, 32'h1000, 23'h10);
            push(1'b1, 2'd2, 32'h3000, 23'h30);
        end
        clear_counts();
        s_px1_cmd_valid = 1'b1; s_px2_cmd_valid = 1'b1; s_w_cmd_valid = 1'b1;
        run(8);
        drop_valids();
        run(2);
        check("c1_px2_ready", 32'(r1_px2), 32'd0);
        check("c1_out_px1", 32'(out1_px1), 32'd2);
        check("c1_out_px2", 32'(out1_px2), 32'd0);
        check("c1_out_w", 32'(out1_w), 32'd2);
        check("c1_queue_empty", 32'(exp1_q.size()), 32'd0);
        done_px2 = 1'b1;
        run(1);
        done_px2 = 1'b0;
        run(1);
        check("c1_done_px2_ignored", 32'(err1_underflow), 32'd0);
        mon1_en = 1'b0;

        // Reset while a command is held in ISSUE
        do_reset();
        mon_en = 1'b1;
        s_w_cmd_addr = 32'h8000; s_w_cmd_len = 23'h80;
        push(1'b0, 2'd2, 32'h8000, 23'h80);
        s_w_cmd_valid = 1'b1;
        run(1);
        s_w_cmd_valid = 1'b0;
        run(1);
        @(negedge aclk);
        check("ri_out_w_pre", 32'(out_w), 32'd1);
        @(posedge aclk);
        #1;
        m_cmd_ready = 1'b0;
        s_px1_cmd_addr = 32'h9000; s_px1_cmd_len = 23'h90;
        s_px1_cmd_valid = 1'b1;
        run(1);
        s_px1_cmd_valid = 1'b0;
        @(negedge aclk);
        check("ri_issue_valid", 32'(m_cmd_valid), 32'd1);
        @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        check("ri_valid_dropped", 32'(m_cmd_valid), 32'd0);
        check("ri_out_w_zero", 32'(out_w), 32'd0);
        check("ri_busy", 32'(busy), 32'd0);
        @(posedge aclk);
        #1;
        m_cmd_ready = 1'b1;
        s_px1_cmd_addr = 32'h9100; s_px1_cmd_len = 23'h91;
        s_px2_cmd_addr = 32'h2000; s_px2_cmd_len = 23'h20;
        s_w_cmd_addr = 32'h3000; s_w_cmd_len = 23'h30;
        s_px1_cmd_valid = 1'b1; s_px2_cmd_valid = 1'b1; s_w_cmd_valid = 1'b1;
        @(negedge aclk);
        check("ri_first_grant_px1", 32'(s_px1_cmd_ready), 32'd1);
        push(1'b0, 2'd0, 32'h9100, 23'h91);
        @(posedge aclk);
        #1;
        drop_valids();
        run(2);
        check("ri_queue_empty", 32'(exp_q.size()), 32'd0);

        // Underflow flag is sticky until reset
        @(negedge aclk);
        check("uf_err_before", 32'(err_underflow), 32'd0);
        @(posedge aclk);
        #1;
        done_w = 1'b1;
        run(1);
        done_w = 1'b0;
        @(negedge aclk);
        check("uf_err_set", 32'(err_underflow), 32'd1);
        check("uf_out_w", 32'(out_w), 32'd0);
        @(posedge aclk);
        #1;
        run(5);
        @(negedge aclk);
        check("uf_err_sticky", 32'(err_underflow), 32'd1);
        @(posedge aclk);
        #1;
        do_reset();
        @(negedge aclk);
        check("uf_err_cleared", 32'(err_underflow), 32'd0);
        @(posedge aclk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
